// File: rtl/calc_seq_ctrl_if.sv
// Calculator-side handshake and shared-adder bus for calc_seq_ctrl.
// slave: the controller. master: the calculator top level and the external adder.
interface calc_seq_ctrl_if;
  logic       start;
  logic [1:0] Op;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] Result;
  logic       Neg;
  logic [3:0] Add_A;
  logic [3:0] Add_B;
  logic       Add_Cin;
  logic [3:0] Add_Sum;
  logic       Add_Cout;

  modport slave (
    input  start, Op, A, B, Add_Sum, Add_Cout,
    output busy, done, Result, Neg, Add_A, Add_B, Add_Cin
  );

  modport master (
    output start, Op, A, B, Add_Sum, Add_Cout,
    input  busy, done, Result, Neg, Add_A, Add_B, Add_Cin
  );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Sequencer time-sharing one external 4-bit adder for ADD/SUB/MUL (and optional DIV).
// Define CALC_SEQ_DIV_EN to make Op=11 a 4-iteration restoring divide.
module calc_seq_ctrl #(
  parameter int unsigned ITER = 4
) (
  input  logic            clk,
  input  logic            rst,
  calc_seq_ctrl_if.slave  bus
);

  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] LastCnt = CntW'(ITER - 1);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
`ifdef CALC_SEQ_DIV_EN
  localparam logic [1:0] OpDiv = 2'b11;
`endif

  typedef enum logic [1:0] {StIdle, StExec, StIter, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic [3:0]      p_hi_q, p_hi_d;
  logic [3:0]      p_lo_q, p_lo_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      result_q, result_d;
  logic            neg_q, neg_d;

  logic [3:0]      add_a;
  logic [3:0]      add_b;
  logic            add_cin;

`ifdef CALC_SEQ_DIV_EN
  // {R,Q} after the left shift, and the bit shifted out of R.
  logic [3:0]      rem_sh;
  logic [3:0]      quo_sh;
  logic            rem_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 2'b00;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      p_hi_q   <= 4'h0;
      p_lo_q   <= 4'h0;
      cnt_q    <= '0;
      result_q <= 8'h00;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    add_a    = 4'h0;
    add_b    = 4'h0;
    add_cin  = 1'b0;
`ifdef CALC_SEQ_DIV_EN
    rem_sh   = 4'h0;
    quo_sh   = 4'h0;
    rem_out  = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d   = bus.Op;
          a_d    = bus.A;
          b_d    = bus.B;
          cnt_d  = '0;
          p_hi_d = 4'h0;
          p_lo_d = 4'h0;
          unique case (bus.Op)
            OpMul: begin
              p_lo_d  = bus.B;
              state_d = StIter;
            end
`ifdef CALC_SEQ_DIV_EN
            OpDiv: begin
              p_lo_d  = bus.A;
              // Divide by zero bypasses the iterations entirely.
              state_d = (bus.B == 4'h0) ? StExec : StIter;
            end
`endif
            default: state_d = StExec;
          endcase
        end
      end

      StExec: begin
        state_d = StDone;
        neg_d   = 1'b0;
        unique case (op_q)
          OpAdd: begin
            add_a    = a_q;
            add_b    = b_q;
            result_d = {3'b000, bus.Add_Cout, bus.Add_Sum};
          end
          OpSub: begin
            add_a    = a_q;
            add_b    = ~b_q;
            add_cin  = 1'b1;
            // No carry out of A + ~B + 1 means a borrow, i.e. A < B.
            neg_d    = ~bus.Add_Cout;
            result_d = {{4{~bus.Add_Cout}}, bus.Add_Sum};
          end
`ifdef CALC_SEQ_DIV_EN
          OpDiv: begin
            result_d = 8'hFF;
          end
`endif
          default: begin
            result_d = 8'h00;
          end
        endcase
      end

      StIter: begin
        cnt_d = cnt_q + CntW'(1);
        if (op_q == OpMul) begin
          add_a  = p_hi_q;
          add_b  = p_lo_q[0] ? a_q : 4'h0;
          p_hi_d = {bus.Add_Cout, bus.Add_Sum[3:1]};
          p_lo_d = {bus.Add_Sum[0], p_lo_q[3:1]};
        end
`ifdef CALC_SEQ_DIV_EN
        else begin
          rem_out = p_hi_q[3];
          rem_sh  = {p_hi_q[2:0], p_lo_q[3]};
          quo_sh  = {p_lo_q[2:0], 1'b0};
          add_a   = rem_sh;
          add_b   = ~b_q;
          add_cin = 1'b1;
          if (rem_out | bus.Add_Cout) begin
            p_hi_d = bus.Add_Sum;
            p_lo_d = {quo_sh[3:1], 1'b1};
          end else begin
            p_hi_d = rem_sh;
            p_lo_d = quo_sh;
          end
        end
`endif
        if (cnt_q == LastCnt) begin
          state_d  = StDone;
          result_d = {p_hi_d, p_lo_d};
          neg_d    = 1'b0;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.Result  = result_q;
  assign bus.Neg     = neg_q;
  assign bus.Add_A   = add_a;
  assign bus.Add_B   = add_b;
  assign bus.Add_Cin = add_cin;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomised and directed bench for calc_seq_ctrl against an arithmetic reference model.
// Honours CALC_SEQ_DIV_EN the same way as the design.
module tb_calc_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  calc_seq_ctrl_if bus ();

  calc_seq_ctrl #(.ITER(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External ripple-carry adder, purely combinational.
  assign {bus.Add_Cout, bus.Add_Sum} = {1'b0, bus.Add_A} + {1'b0, bus.Add_B}
                                     + {4'b0000, bus.Add_Cin};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                output logic [7:0] res, output logic neg, output int lat);
    int d;
    neg = 1'b0;
    lat = 2;
    case (op)
      2'b00: res = 8'(int'(a) + int'(b));
      2'b01: begin
        d   = int'(a) - int'(b);
        neg = (d < 0);
        res = 8'(d);
      end
      2'b10: begin
        res = 8'(int'(a) * int'(b));
        lat = 5;
      end
      default: begin
`ifdef CALC_SEQ_DIV_EN
        if (b == 4'h0) begin
          res = 8'hFF;
        end else begin
          res = {4'(a % b), 4'(a / b)};
          lat = 5;
        end
`else
        res = 8'h00;
`endif
      end
    endcase
  endfunction

  // Issue one operation from IDLE and check timing, outputs and adder drive.
  // poke: pulse start with junk operands while busy; it must be ignored.
  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input bit poke);
    logic [7:0] exp_res;
    logic       exp_neg;
    int         exp_lat;
    int         got_lat;
    model(op, a, b, exp_res, exp_neg, exp_lat);
    got_lat = 0;
    bus.start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
      end
      if (op == 2'b10 && k <= 4) begin
        check_eq("mul_add_b", 32'(bus.Add_B), b[k-1] ? 32'(a) : 32'd0);
        check_eq("mul_add_cin", 32'(bus.Add_Cin), 32'd0);
      end
      if (poke && k == 2) begin
        bus.start = 1'b1;
        bus.Op    = 2'b00;
      end
      if (bus.done) begin
        got_lat = k;
        break;
      end
    end
    check_eq("latency", 32'(got_lat), 32'(exp_lat));
    check_eq("result", 32'(bus.Result), 32'(exp_res));
    check_eq("neg", 32'(bus.Neg), 32'(exp_neg));
    check_eq("busy_in_done", 32'(bus.busy), 32'd1);
    check_eq("adder_idle_done", {bus.Add_A, bus.Add_B, 3'b000, bus.Add_Cin}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    check_eq("idle_done", 32'(bus.done), 32'd0);
    check_eq("result_hold", 32'(bus.Result), 32'(exp_res));
    if (poke) begin
      repeat (2) @(negedge clk);
      check_eq("poke_not_queued", 32'(bus.busy), 32'd0);
      check_eq("poke_result_hold", 32'(bus.Result), 32'(exp_res));
    end
  endtask

  // Hold start high for a window and count done pulses and their results.
  task automatic run_stream(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                            input int exp_dones);
    logic [7:0] exp_res;
    logic       exp_neg;
    int         exp_lat;
    int         dones;
    model(op, a, b, exp_res, exp_neg, exp_lat);
    dones = 0;
    bus.start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        check_eq("stream_result", 32'(bus.Result), 32'(exp_res));
      end
    end
    bus.start = 1'b0;
    check_eq("stream_done_count", 32'(dones), 32'(exp_dones));
    for (int k = 0; k < 8 && bus.busy; k++) @(negedge clk);
    @(negedge clk);
    check_eq("stream_settle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.Op    = 2'b00;
    bus.A     = 4'h0;
    bus.B     = 4'h0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_result", 32'(bus.Result), 32'd0);
    check_eq("rst_neg", 32'(bus.Neg), 32'd0);
    check_eq("rst_adder", {bus.Add_A, bus.Add_B, 3'b000, bus.Add_Cin}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b00, 4'd9, 4'd8, 1'b0);
    run_op(2'b00, 4'd0, 4'd0, 1'b0);
    run_op(2'b01, 4'd3, 4'd5, 1'b0);
    run_op(2'b01, 4'd0, 4'd15, 1'b0);
    run_op(2'b01, 4'd7, 4'd7, 1'b0);
    run_op(2'b10, 4'd15, 4'd15, 1'b0);
    run_op(2'b10, 4'd6, 4'd0, 1'b0);
    run_op(2'b10, 4'd11, 4'd5, 1'b1);
    run_op(2'b00, 4'd4, 4'd12, 1'b1);
    run_op(2'b11, 4'd13, 4'd4, 1'b0);
    run_op(2'b11, 4'd9, 4'd0, 1'b0);

    run_stream(2'b00, 4'd5, 4'd6, 10);
    run_stream(2'b10, 4'd7, 4'd3, 5);

    // Reset during the second multiply iteration.
    bus.start = 1'b1;
    bus.Op    = 2'b10;
    bus.A     = 4'd9;
    bus.B     = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_result", 32'(bus.Result), 32'd0);
    check_eq("abort_adder", {bus.Add_A, bus.Add_B, 3'b000, bus.Add_Cin}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_op(2'b00, 4'd2, 4'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
